rf_dump_reader: RTL and testbench
=================================

Name: rf_dump_reader

Overview:
- Reader-side companion to the CPU register file's debug read port (reg_sel / reg_data).
- On command, walks a range of architectural registers and streams each {index, value} pair out over a valid/ready interface, for debug consoles and the board display path.
- Sits between the register file debug port and a display/UART-style consumer.
- Never writes the register file.

Parameters:
- FIRST_REG, 0, lowest register index dumped in range mode (0..31).
- LAST_REG, 31, highest register index dumped in range mode (FIRST_REG..31).
- SETTLE, 1, cycles between driving reg_sel and sampling reg_data (1..7).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; ignored unless FSM is IDLE.
- single  in  1  sampled with start: 1 = dump only sel_in, 0 = dump FIRST_REG..LAST_REG.
- sel_in  in  5  register index for single mode, sampled with start.
- abort  in  1  terminates any dump at the next edge.
- reg_sel  out  5  index driven to register file debug port.
- reg_data  in  32  combinational register value for reg_sel.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  consumer accepts beat when out_valid & out_ready at posedge.
- out_idx  out  5  register index of current beat.
- out_data  out  32  captured register value.
- out_last  out  1  marks final beat of a dump.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after last beat accepted, or after abort.

Behaviour:
- Reset (rst low, async): state=IDLE; reg_sel=0, out_valid=0, out_idx=0, out_data=0, out_last=0, busy=0, done=0; settle counter=0.
- States and transitions:
  - IDLE: on start, latch cur = single ? sel_in : FIRST_REG and end = single ? sel_in : LAST_REG; go to SEL.
  - SEL: drive reg_sel=cur; count SETTLE cycles, then go to CAP. The sample is taken on the edge ending the SETTLE-th cycle.
  - CAP: out_data<=reg_data, out_idx<=cur, out_last<=(cur==end), out_valid<=1; go to SEND. Takes 1 cycle.
  - SEND: hold all out_* stable while out_valid & !out_ready (AXI-style; no combinational ready->valid path).
    - On accept, if out_last: out_valid<=0, go to DONE.
    - Otherwise: cur<=cur+1, out_valid<=0, go to SEL.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Latency, range mode: start to first out_valid = 1 + SETTLE + 1 cycles. Each later beat follows SETTLE+1 cycles after the prior accept.
- reg_sel holds its last driven value in SEND/DONE/IDLE. It is not forced to 0.
- Index 0: reads as 0 from the register file and is streamed as a normal beat with out_data=0.
- Width/arithmetic:
  - cur is 5 bits; the increment never wraps because cur<=end<=31 is checked before incrementing.
  - FIRST_REG>LAST_REG is illegal; the implementation asserts on it in simulation.
- Single mode: exactly one beat with out_last=1.
- Concurrency:
  - Register-file writes (on negedge) between SEL and CAP are fine; the value present at the sampling posedge is streamed.
  - No coherency snapshot across the dump.
- abort:
  - In any non-IDLE, non-DONE state: next state is DONE, out_valid<=0, out_last<=0. A pending beat is dropped even if out_ready is high the same cycle.
  - abort has priority over accept.
  - In IDLE it is ignored.
- start while busy: ignored, no queuing. start and abort together in IDLE: start wins.
- Reset mid-dump: immediate return to IDLE with reset values; no done pulse.

Decomposition:
- Shared package (cpu_dbg_pkg):
  - State encoding constants: IDLE, SEL, CAP, SEND, DONE.
  - Register index width (5) and data width (32).
  - Reused by the display/UART consumer.
- One natural sub-module, rf_dump_settle_cnt: 3-bit down-counter with load and zero flag, used by SEL.
- Everything else lives in a single always block plus output registers.

Test Plan:
- Range dump, defaults: preload r1..r31 = 0x1000_0000+i, out_ready=1 → 32 beats with idx 0..31, data 0 then 0x1000_0001..0x1000_001F. out_last only on idx 31. done pulse one cycle after last accept. First out_valid 3 cycles after start.
- Single mode, sel_in=7, r7=0xDEADBEEF → one beat, idx=7, data=0xDEADBEEF, out_last=1; busy falls after the done cycle.
- Backpressure: out_ready low 5 cycles on beat idx=3 → out_valid/out_idx/out_data/out_last stable all 5 cycles; stream resumes with idx 4, no loss or duplication.
- Abort: assert abort while beat idx=10 is valid with out_ready=1 → no accept, out_valid drops, done pulses next cycle, FSM returns to IDLE. A new start restarts from FIRST_REG.
- Reset mid-dump: drive rst low asynchronously during SEL of idx 5 → all outputs at reset values before the next edge; no done pulse.
- Concurrent write: with SETTLE=3, write r12=0x55AA55AA during SEL of idx 12 → streamed value 0x55AA55AA. A start pulse while busy is ignored, and the beat count is unchanged.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug register-file reader and its stream consumers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_dbg_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_IDX_W-1:0]  reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // Dump walker states; the display/UART consumer decodes the same encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/rf_dump_settle_cnt.sv
// Settle-time down-counter: load a count, decrement to zero, flag zero.
// Latency: load/decrement visible the cycle after the edge; zero flag is combinational from the count.
// Backpressure: none; the count saturates at zero.
// Ports: clk, rst (async active-low), load/load_val, dec, zero.
module rf_dump_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/rf_dump_reader.sv
// Walks a register-file index range (or one index) and streams {idx, value} beats.
// Latency: start to first out_valid = SETTLE + 2 cycles; SETTLE + 1 cycles from each accept to the next beat.
// Backpressure: out_* held stable while out_valid & !out_ready; no combinational ready-to-valid path.
// Ports: clk, rst (async active-low); command start/single/sel_in/abort; register file
// debug port reg_sel/reg_data; stream out_valid/out_ready/out_idx/out_data/out_last; status busy/done.
module rf_dump_reader
    import cpu_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        single,
    input  logic [4:0]  sel_in,
    input  logic        abort,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam reg_idx_t   FIRST_IDX = reg_idx_t'(FIRST_REG);
    localparam reg_idx_t   LAST_IDX  = reg_idx_t'(LAST_REG);
    localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);

    generate
        if ((FIRST_REG > LAST_REG) || (LAST_REG > 31) || (FIRST_REG < 0) ||
            (SETTLE < 1) || (SETTLE > 7)) begin : g_bad_param
            $error("rf_dump_reader: illegal FIRST_REG/LAST_REG/SETTLE combination");
        end
    endgenerate

    dump_state_t state, state_nxt;
    reg_idx_t    cur;
    reg_idx_t    end_idx;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        accept;

    assign accept = out_valid & out_ready;

    // The counter is loaded with SETTLE-1 on entry to SEL, so SEL lasts exactly SETTLE cycles.
    rf_dump_settle_cnt u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks accept; in IDLE start outranks abort because abort is not looked at there.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SEL;
                    cnt_load  = 1'b1;
                end
            end
            ST_SEL: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (cnt_zero) begin
                    state_nxt = ST_CAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CAP: begin
                state_nxt = abort ? ST_DONE : ST_SEND;
            end
            ST_SEND: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (accept) begin
                    if (out_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SEL;
                        cnt_load  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= '0;
            end_idx   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur     <= single ? sel_in : FIRST_IDX;
                        end_idx <= single ? sel_in : LAST_IDX;
                    end
                end
                ST_SEL: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                ST_CAP: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else begin
                        out_data  <= reg_data;
                        out_idx   <= cur;
                        out_last  <= (cur == end_idx);
                        out_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        // Only reached with cur < end_idx <= 31, so the increment cannot wrap.
                        if (!out_last) begin
                            cur <= cur + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The debug port follows the walk pointer and simply keeps its last value when idle.
    assign reg_sel = cur;

endmodule

// File: tb/tb_rf_dump_reader.sv
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3, single, abort, out_ready;
    logic [4:0]  sel_in;

    logic [4:0]  reg_sel, out_idx;
    logic [31:0] reg_data, out_data;
    logic        out_valid, out_last, busy, done;

    logic [4:0]  reg_sel3, out_idx3;
    logic [31:0] reg_data3, out_data3;
    logic        out_valid3, out_last3, busy3, done3;

    logic [31:0] rf [32];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic        use3 = 1'b0;
    int          t_start;
    int          first_valid_cyc;
    logic        wrote;
    int          got_idx[$];
    logic [31:0] got_data[$];
    logic        got_last[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: index 0 always reads as zero.
    assign reg_data  = (reg_sel  == 5'd0) ? 32'd0 : rf[reg_sel];
    assign reg_data3 = (reg_sel3 == 5'd0) ? 32'd0 : rf[reg_sel3];

    logic        v_valid, v_last, v_busy, v_done;
    logic [4:0]  v_idx, v_sel;
    logic [31:0] v_data;
    assign v_valid = use3 ? out_valid3 : out_valid;
    assign v_last  = use3 ? out_last3  : out_last;
    assign v_busy  = use3 ? busy3      : busy;
    assign v_done  = use3 ? done3      : done;
    assign v_idx   = use3 ? out_idx3   : out_idx;
    assign v_sel   = use3 ? reg_sel3   : reg_sel;
    assign v_data  = use3 ? out_data3  : out_data;

    rf_dump_reader u_dut (
        .clk(clk), .rst(rst), .start(start), .single(single), .sel_in(sel_in),
        .abort(abort), .reg_sel(reg_sel), .reg_data(reg_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .single(single), .sel_in(sel_in),
        .abort(abort), .reg_sel(reg_sel3), .reg_data(reg_data3), .out_valid(out_valid3),
        .out_ready(out_ready), .out_idx(out_idx3), .out_data(out_data3),
        .out_last(out_last3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic sng, input logic [4:0] sel);
        single = sng;
        sel_in = sel;
        if (use3) start3 = 1'b1;
        else      start  = 1'b1;
        t_start = cyc;
        tick;
        start  = 1'b0;
        start3 = 1'b0;
        chk("busy_after_start", 32'(v_busy), 32'd1);
    endtask

    task automatic randomize_rf;
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i[4:0]] = $urandom;
    endtask

    // Drives out_ready, optional stall/abort/write/stray-start events, and records accepted beats.
    task automatic collect(input int budget, input int stall_idx, input int stall_len,
                           input int abort_idx, input int write_idx, input int dup_start_at,
                           input logic rnd_ready);
        logic        finished;
        logic        stalled;
        logic [4:0]  s_idx;
        logic [31:0] s_data;
        logic        s_last;
        finished = 1'b0;
        stalled  = 1'b0;
        got_idx.delete();
        got_data.delete();
        got_last.delete();
        first_valid_cyc = -1;
        wrote = 1'b0;
        for (int c = 0; c < budget && !finished; c++) begin
            abort = 1'b0;
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (c == dup_start_at) begin
                if (use3) start3 = 1'b1;
                else      start  = 1'b1;
            end
            if (v_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (write_idx >= 0 && !wrote && v_busy && !v_valid && int'(v_sel) == write_idx) begin
                @(negedge clk);
                rf[write_idx[4:0]] = 32'h55AA55AA;
                wrote = 1'b1;
            end
            if (v_valid && int'(v_idx) == stall_idx && !stalled) begin
                stalled   = 1'b1;
                s_idx     = v_idx;
                s_data    = v_data;
                s_last    = v_last;
                out_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    tick;
                    chk($sformatf("stall_valid[%0d]", k), 32'(v_valid), 32'd1);
                    chk($sformatf("stall_idx[%0d]", k), 32'(v_idx), 32'(s_idx));
                    chk($sformatf("stall_data[%0d]", k), v_data, s_data);
                    chk($sformatf("stall_last[%0d]", k), 32'(v_last), 32'(s_last));
                end
                out_ready = 1'b1;
            end
            if (v_valid && int'(v_idx) == abort_idx) begin
                out_ready = 1'b1;
                abort = 1'b1;
                tick;
                abort = 1'b0;
                chk("abort_valid_drop", 32'(v_valid), 32'd0);
                chk("abort_done_pulse", 32'(v_done), 32'd1);
                tick;
                chk("abort_busy_idle", 32'(v_busy), 32'd0);
                chk("abort_done_once", 32'(v_done), 32'd0);
                finished = 1'b1;
            end else if (v_valid && out_ready) begin
                got_idx.push_back(int'(v_idx));
                got_data.push_back(v_data);
                got_last.push_back(v_last);
                if (v_last) begin
                    tick;
                    start  = 1'b0;
                    start3 = 1'b0;
                    chk("done_pulse", 32'(v_done), 32'd1);
                    chk("valid_after_last", 32'(v_valid), 32'd0);
                    tick;
                    chk("done_one_cycle", 32'(v_done), 32'd0);
                    chk("busy_fall", 32'(v_busy), 32'd0);
                    finished = 1'b1;
                end else begin
                    tick;
                end
            end else begin
                tick;
            end
            start  = 1'b0;
            start3 = 1'b0;
        end
        chk("collect_in_budget", 32'(finished), 32'd1);
    endtask

    // Reference: beats first..first+n-1, value from the register file, last only on idx == last.
    task automatic check_beats(input int first, input int last, input int n_expected);
        chk("beat_count", got_idx.size(), n_expected);
        for (int i = 0; i < got_idx.size() && i < n_expected; i++) begin
            int e;
            e = first + i;
            chk($sformatf("beat_idx[%0d]", i), got_idx[i], e);
            chk($sformatf("beat_data[%0d]", i), got_data[i], (e == 0) ? 32'd0 : rf[e[4:0]]);
            chk($sformatf("beat_last[%0d]", i), 32'(got_last[i]), 32'(e == last));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst = 1'b0; start = 1'b0; start3 = 1'b0; single = 1'b0; sel_in = 5'd0;
        abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i[4:0]] = 32'd0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        chk("rst_reg_sel", 32'(reg_sel), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        rst = 1'b1;
        tick;

        // Range dump with fixed pattern, ready always high
        for (int i = 1; i < 32; i++) rf[i[4:0]] = 32'h1000_0000 + i;
        use3 = 1'b0;
        kick(1'b0, 5'd0);
        collect(400, -1, 0, -1, -1, -1, 1'b0);
        chk("latency_settle1", first_valid_cyc - t_start, 3);
        check_beats(0, 31, 32);

        // Single mode
        rf[7] = 32'hDEADBEEF;
        kick(1'b1, 5'd7);
        collect(50, -1, 0, -1, -1, -1, 1'b0);
        check_beats(7, 7, 1);

        // Random single reads including index 0, random backpressure
        for (int k = 0; k < 5; k++) begin
            int s;
            randomize_rf;
            s = (k == 0) ? 0 : int'($urandom_range(0, 31));
            kick(1'b1, 5'(s));
            collect(100, -1, 0, -1, -1, -1, 1'b1);
            check_beats(s, s, 1);
        end

        // Range dump with a 5-cycle stall on idx 3 plus random ready
        randomize_rf;
        kick(1'b0, 5'd0);
        collect(800, 3, 5, -1, -1, -1, 1'b1);
        check_beats(0, 31, 32);

        // Abort while idx 10 is valid with ready high, then restart
        randomize_rf;
        kick(1'b0, 5'd0);
        collect(400, -1, 0, 10, -1, -1, 1'b0);
        check_beats(0, 31, 10);
        kick(1'b0, 5'd0);
        collect(800, -1, 0, -1, -1, -1, 1'b1);
        chk("restart_first_idx", (got_idx.size() > 0) ? got_idx[0] : -1, 0);
        check_beats(0, 31, 32);

        // Asynchronous reset during SEL of idx 5
        kick(1'b0, 5'd0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            out_ready = 1'b1;
            if (busy && !out_valid && reg_sel == 5'd5) found = 1'b1;
            else tick;
        end
        chk("reset_hit_sel5", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_reg_sel", 32'(reg_sel), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_idx", 32'(out_idx), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        tick;
        chk("midrst_no_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick;
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_done", 32'(done), 32'd0);

        // SETTLE=3: register write during SEL of idx 12, stray start while busy
        use3 = 1'b1;
        randomize_rf;
        kick(1'b0, 5'd0);
        collect(1500, -1, 0, -1, 12, 40, 1'b0);
        chk("settle3_write_hit", 32'(wrote), 32'd1);
        chk("latency_settle3", first_valid_cyc - t_start, 5);
        chk("settle3_r12", (got_data.size() > 12) ? got_data[12] : 32'd0, 32'h55AA55AA);
        check_beats(0, 31, 32);
        use3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
